// File: rtl/peripheral_mpi_packet_arbiter.sv
// peripheral_mpi_packet_arbiter: packet-atomic round-robin arbiter onto one registered NoC link
module peripheral_mpi_packet_arbiter #(
  parameter int NOC_FLIT_WIDTH = 32,
  parameter int N = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N*NOC_FLIT_WIDTH-1:0] in_flit,
  input  logic [N-1:0]                in_last,
  input  logic [N-1:0]                in_valid,
  output logic [N-1:0]                in_ready,
  output logic [NOC_FLIT_WIDTH-1:0]   out_flit,
  output logic                        out_last,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [N-1:0]                grant,
  output logic                        busy
);
  localparam int PW = N > 1 ? $clog2(N) : 1;
  localparam int SW = PW + 1;
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_LOCKED = 1'b1;
  logic [0:0] r_state;
  logic [PW-1:0] r_rr_ptr, r_owner;
  logic [N-1:0] r_grant;
  logic [NOC_FLIT_WIDTH-1:0] r_out_flit;
  logic r_out_last, r_out_valid;
  logic w_accept, w_found, w_req, w_xfer, w_last;
  logic [PW-1:0] w_win, w_sel, w_next;
  logic [PW-1:0] w_cand [N];
  logic [NOC_FLIT_WIDTH-1:0] w_flit;
  // w_cand[k] is the k-th requester in round-robin order starting at r_rr_ptr
  for (genvar g = 0; g < N; g++) begin : g_cand
    logic [SW-1:0] w_sum;
    assign w_sum = {1'b0, r_rr_ptr} + SW'(g);
    assign w_cand[g] = w_sum >= SW'(N) ? PW'(w_sum - SW'(N)) : PW'(w_sum);
  end
  always_comb begin
    w_found = 1'b0;
    w_win = '0;
    for (int k = 0; k < N; k++) begin
      if (!w_found && in_valid[w_cand[k]]) begin
        w_found = 1'b1;
        w_win = w_cand[k];
      end
    end
  end
  assign w_accept = !r_out_valid || out_ready;
  assign w_sel = r_state == S_LOCKED ? r_owner : w_win;
  assign w_req = r_state == S_LOCKED ? in_valid[w_sel] : w_found;
  assign w_xfer = !rst && w_req && w_accept;
  assign in_ready = w_xfer ? N'(1) << w_sel : '0;
  assign w_next = w_sel == PW'(N - 1) ? '0 : w_sel + PW'(1);
  assign w_flit = in_flit[w_sel*NOC_FLIT_WIDTH +: NOC_FLIT_WIDTH];
  assign w_last = in_last[w_sel];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_rr_ptr <= '0;
      r_owner <= '0;
      r_grant <= '0;
      r_out_flit <= '0;
      r_out_last <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= w_xfer;
      if (w_xfer) begin
        r_out_flit <= w_flit;
        r_out_last <= w_last;
        r_state <= w_last ? S_IDLE : S_LOCKED;
        r_owner <= w_sel;
        r_grant <= w_last ? '0 : in_ready;
        if (w_last) r_rr_ptr <= w_next;
      end
    end
  end
  assign out_flit = r_out_flit;
  assign out_last = r_out_last;
  assign out_valid = r_out_valid;
  assign grant = r_grant;
  assign busy = r_state == S_LOCKED;
endmodule
